// File: rtl/linear_diffusion_seq.sv
// ASCON pL linear diffusion layer, LANES_PER_CYCLE lanes per clock, valid/ready on both sides.
// Optional bypass_i port (lanes pass through unchanged) when LINEAR_DIFFUSION_BYPASS_EN is defined.
module linear_diffusion_seq #(
    parameter int WORD_W          = 64,
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic                clock_i,
    input  logic                resetb_i,
`ifdef LINEAR_DIFFUSION_BYPASS_EN
    input  logic                bypass_i,
`endif
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [5*WORD_W-1:0] state_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [5*WORD_W-1:0] state_o
);

    if ((LANES_PER_CYCLE != 1 && LANES_PER_CYCLE != 5) || WORD_W < 8 || WORD_W > 64) begin : g_bad_cfg
        $error("linear_diffusion_seq: LANES_PER_CYCLE must be 1 or 5 and WORD_W 8..64");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t                state_q;
    fsm_t                state_d;
    logic [5*WORD_W-1:0] reg_q;
    logic [5*WORD_W-1:0] all_new;
    logic [WORD_W-1:0]   lane_cur;
    logic [WORD_W-1:0]   lane_new;
    logic [2:0]          lane_cnt;
    logic                ready_q;
    logic                bypass_q;
    logic                bypass_in;
    logic                accept;

`ifdef LINEAR_DIFFUSION_BYPASS_EN
    assign bypass_in = bypass_i;
`else
    assign bypass_in = 1'b0;
`endif

    // Shift by WORD_W yields zero, so n == 0 degenerates cleanly to x.
    function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int n);
        ror = (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] diffuse(input logic [WORD_W-1:0] x, input logic [2:0] lane);
        int a;
        int b;
        case (lane)
            3'd0:    begin a = 19; b = 28; end
            3'd1:    begin a = 61; b = 39; end
            3'd2:    begin a = 1;  b = 6;  end
            3'd3:    begin a = 10; b = 17; end
            default: begin a = 7;  b = 41; end
        endcase
        diffuse = x ^ ror(x, a % WORD_W) ^ ror(x, b % WORD_W);
    endfunction

    assign accept = (state_q == IDLE) && ready_q && in_valid_i;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LANES_PER_CYCLE == 5) state_d = DONE;
                    else                      state_d = BUSY;
                end
            end
            BUSY:    if (lane_cnt == 3'd4) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_o = (state_q == DONE);
        in_ready_o  = ready_q;
        state_o     = reg_q;
    end

    // One shared rotator pair, fed by the lane selected by lane_cnt.
    always_comb begin
        lane_cur = reg_q[int'(lane_cnt)*WORD_W +: WORD_W];
        lane_new = bypass_q ? lane_cur : diffuse(lane_cur, lane_cnt);
    end

    always_comb begin
        all_new = '0;
        for (int k = 0; k < 5; k++) begin
            all_new[k*WORD_W +: WORD_W] = bypass_in ? state_i[k*WORD_W +: WORD_W]
                                                    : diffuse(state_i[k*WORD_W +: WORD_W], 3'(k));
        end
    end

    // ready_q is a registered decode of the next state so it stays low while reset is held.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            reg_q    <= '0;
            lane_cnt <= 3'd0;
            ready_q  <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            ready_q <= (state_d == IDLE);
            if (accept) begin
                bypass_q <= bypass_in;
                lane_cnt <= 3'd0;
                reg_q    <= (LANES_PER_CYCLE == 5) ? all_new : state_i;
            end else if (state_q == BUSY) begin
                reg_q[int'(lane_cnt)*WORD_W +: WORD_W] <= lane_new;
                lane_cnt <= (lane_cnt == 3'd4) ? 3'd0 : lane_cnt + 3'd1;
            end
        end
    end

endmodule
